// File: rtl/answer_judge.sv
// rtl/answer_judge.sv - factorization answer judge, checks d1*d2*d3 == N with a timeout (optional streak counter: STREAK_EN)
module answer_judge #(
  parameter int TIME_LIMIT = 500000000,
  parameter int TW         = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  STATE,
  input  logic [23:0] QUESTION,
  input  logic        DEC,
  input  logic [3:0]  COUNT1_OUT,
  input  logic [3:0]  COUNT2_OUT,
  input  logic [3:0]  COUNT3_OUT,
  output logic [1:0]  RESULT,
  output logic        RES_VALID,
  output logic        BUSY,
  output logic [3:0]  STREAK
);

  localparam logic [3:0]    ST_INPUT    = 4'b0100;
  localparam logic [1:0]    RES_CORRECT = 2'b01;
  localparam logic [1:0]    RES_WRONG   = 2'b10;
  localparam logic [1:0]    RES_TIMEOUT = 2'b11;
  localparam logic [TW-1:0] LIMIT_LAST  = TW'(TIME_LIMIT - 1);
  // Parking value once the timeout has fired, so it fires only once per INPUT stay
  localparam logic [TW-1:0] LIMIT_DONE  = TW'(TIME_LIMIT);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_MUL1, S_MUL2, S_CMP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    d1_q, d2_q, d3_q;
  logic [3:0]    q_h, q_t, q_o;
  logic [9:0]    prod_q;
  logic [TW-1:0] timer_q;
  logic [9:0]    n_val;
  logic          in_input;
  logic          timeout_fire;
  logic          verdict_ok;
  logic          unused_question;

  assign unused_question = ^QUESTION[11:0];
  assign in_input        = (STATE == ST_INPUT);
  assign BUSY            = (state_q != S_IDLE);

  // A pending decide on the same edge takes precedence over the timeout
  assign timeout_fire = in_input && (state_q == S_IDLE) && !DEC && (timer_q == LIMIT_LAST);

  // Target number from the captured BCD digits; invalid nibbles are rejected separately
  assign n_val = 10'(q_h) * 10'd100 + 10'(q_t) * 10'd10 + 10'(q_o);

  assign verdict_ok = (q_h <= 4'd9) && (q_t <= 4'd9) && (q_o <= 4'd9) &&
                      (d1_q != 4'd0) && (d2_q != 4'd0) && (d3_q != 4'd0) &&
                      (n_val != 10'd0) && (prod_q == n_val);

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; leaving INPUT mid-judgment aborts silently
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_input && DEC) state_d = S_WAIT;
      S_WAIT:  state_d = in_input ? S_MUL1 : S_IDLE;
      S_MUL1:  state_d = in_input ? S_MUL2 : S_IDLE;
      S_MUL2:  state_d = in_input ? S_CMP  : S_IDLE;
      S_CMP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture, sequential multiply, verdict and timeout timer
  always_ff @(posedge CLK) begin
    if (RST) begin
      d1_q      <= 4'd0;
      d2_q      <= 4'd0;
      d3_q      <= 4'd0;
      q_h       <= 4'd0;
      q_t       <= 4'd0;
      q_o       <= 4'd0;
      prod_q    <= 10'd0;
      timer_q   <= '0;
      RESULT    <= 2'b00;
      RES_VALID <= 1'b0;
    end else begin
      RES_VALID <= 1'b0;
      if (state_q == S_WAIT) begin
        d1_q <= COUNT1_OUT;
        d2_q <= COUNT2_OUT;
        d3_q <= COUNT3_OUT;
        q_h  <= QUESTION[23:20];
        q_t  <= QUESTION[19:16];
        q_o  <= QUESTION[15:12];
      end
      if (state_q == S_MUL1) prod_q <= 10'(8'(d1_q) * 8'(d2_q));
      if (state_q == S_MUL2) prod_q <= prod_q * 10'(d3_q);
      if (state_q == S_CMP) begin
        RESULT    <= verdict_ok ? RES_CORRECT : RES_WRONG;
        RES_VALID <= 1'b1;
      end
      if (!in_input) begin
        timer_q <= '0;
      end else if (state_q == S_IDLE) begin
        if (DEC) begin
          timer_q <= '0;
        end else if (timeout_fire) begin
          timer_q   <= LIMIT_DONE;
          RESULT    <= RES_TIMEOUT;
          RES_VALID <= 1'b1;
        end else if (timer_q < LIMIT_LAST) begin
          timer_q <= timer_q + 1'b1;
        end
      end
    end
  end

`ifdef STREAK_EN
  logic [3:0] streak_q;
  assign STREAK = streak_q;

  // Consecutive-correct counter, saturating at 9, cleared by any miss
  always_ff @(posedge CLK) begin
    if (RST) begin
      streak_q <= 4'd0;
    end else if (state_q == S_CMP) begin
      if (!verdict_ok)             streak_q <= 4'd0;
      else if (streak_q < 4'd9)    streak_q <= streak_q + 4'd1;
    end else if (timeout_fire) begin
      streak_q <= 4'd0;
    end
  end
`else
  assign STREAK = 4'b0;
`endif

endmodule

// File: tb/tb_answer_judge.sv
// tb/tb_answer_judge.sv - self-checking bench for answer_judge against a digit-rule reference model
module tb_answer_judge;

  localparam int TL = 20;
  localparam logic [3:0] ST_IN    = 4'b0100;
  localparam logic [3:0] ST_OTHER = 4'b0010;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  STATE;
  logic [23:0] QUESTION;
  logic        DEC;
  logic [3:0]  COUNT1_OUT, COUNT2_OUT, COUNT3_OUT;
  logic [1:0]  RESULT;
  logic        RES_VALID;
  logic        BUSY;
  logic [3:0]  STREAK;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_result = 0;
  int streak_ref = 0;

  always #5 CLK = ~CLK;

  answer_judge #(.TIME_LIMIT(TL), .TW(8)) dut (
    .CLK(CLK), .RST(RST), .STATE(STATE), .QUESTION(QUESTION), .DEC(DEC),
    .COUNT1_OUT(COUNT1_OUT), .COUNT2_OUT(COUNT2_OUT), .COUNT3_OUT(COUNT3_OUT),
    .RESULT(RESULT), .RES_VALID(RES_VALID), .BUSY(BUSY), .STREAK(STREAK)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Verdict straight from the game rules: 1 correct, 2 wrong
  function automatic int model_verdict(input logic [23:0] q, input int a, input int b, input int c);
    int h, t, o, n;
    h = int'(q[23:20]);
    t = int'(q[19:16]);
    o = int'(q[15:12]);
    if (h > 9 || t > 9 || o > 9) return 2;
    n = 100 * h + 10 * t + o;
    if (n == 0 || a == 0 || b == 0 || c == 0) return 2;
    return (a * b * c == n) ? 1 : 2;
  endfunction

  function automatic int exp_streak();
`ifdef STREAK_EN
    return streak_ref;
`else
    return 0;
`endif
  endfunction

  function automatic logic [23:0] bcd_question(input int n);
    return {4'(n / 100), 4'((n % 100) / 10), 4'(n % 10), 12'($urandom)};
  endfunction

  task automatic note_verdict(input int v);
    exp_result = v;
    if (v == 1) streak_ref = (streak_ref < 9) ? streak_ref + 1 : 9;
    else        streak_ref = 0;
  endtask

  // One full judgment; inputs are scrambled after capture to prove they are latched
  task automatic do_judge(input logic [23:0] q, input int a, input int b, input int c);
    STATE = ST_IN; QUESTION = q; DEC = 1'b1;
    tick;
    DEC = 1'b0;
    COUNT1_OUT = 4'(a); COUNT2_OUT = 4'(b); COUNT3_OUT = 4'(c);
    chk("busy_e0", 32'(BUSY), 1);
    tick;
    QUESTION = 24'($urandom);
    COUNT1_OUT = 4'($urandom); COUNT2_OUT = 4'($urandom); COUNT3_OUT = 4'($urandom);
    chk("busy_e1", 32'(BUSY), 1);
    chk("valid_e1", 32'(RES_VALID), 0);
    tick;
    chk("busy_e2", 32'(BUSY), 1);
    tick;
    chk("busy_e3", 32'(BUSY), 1);
    chk("valid_e3", 32'(RES_VALID), 0);
    tick;
    note_verdict(model_verdict(q, a, b, c));
    chk("valid_e4", 32'(RES_VALID), 1);
    chk("result", 32'(RESULT), 32'(exp_result));
    chk("busy_e4", 32'(BUSY), 0);
    chk("streak", 32'(STREAK), 32'(exp_streak()));
    STATE = ST_OTHER;
    tick;
    chk("valid_e5", 32'(RES_VALID), 0);
    chk("result_hold", 32'(RESULT), 32'(exp_result));
  endtask

  initial begin
    int a, b, c, first, pulses, p0, p1;
    logic [23:0] q;

    RST = 1'b1; STATE = 4'd0; DEC = 1'b0; QUESTION = 24'd0;
    COUNT1_OUT = 4'd0; COUNT2_OUT = 4'd0; COUNT3_OUT = 4'd0;
    tick; tick;
    chk("rst_result", 32'(RESULT), 0);
    chk("rst_valid", 32'(RES_VALID), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_streak", 32'(STREAK), 0);
    RST = 1'b0;
    tick;

    do_judge(24'h168000, 3, 7, 8);
    do_judge(24'h168000, 2, 9, 9);
    do_judge(24'h168000, 0, 7, 8);
    do_judge(24'h000000, 0, 0, 0);
    do_judge(24'h1A0000, 2, 5, 1);
    for (int i = 0; i < 3; i++) begin
      a = int'($urandom_range(9, 1)); b = int'($urandom_range(9, 1)); c = int'($urandom_range(9, 1));
      do_judge(bcd_question(a * b * c), a, b, c);
    end

    // Timeout fires once after TL edges in INPUT and then stays quiet
    STATE = ST_OTHER; tick;
    STATE = ST_IN; first = -1; pulses = 0;
    for (int k = 1; k <= 2 * TL; k++) begin
      tick;
      if (RES_VALID === 1'b1) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    note_verdict(3);
    chk("timeout_edge", 32'(first), 32'(TL));
    chk("timeout_pulses", 32'(pulses), 1);
    chk("timeout_result", 32'(RESULT), 3);
    chk("timeout_streak", 32'(STREAK), 32'(exp_streak()));
    STATE = ST_OTHER; tick;
    STATE = ST_IN; first = -1;
    for (int k = 1; k <= TL + 5; k++) begin
      tick;
      if (RES_VALID === 1'b1 && first < 0) first = k;
    end
    chk("timeout_restart", 32'(first), 32'(TL));

    // Abort from MUL1 leaves RESULT untouched
    do_judge(24'h729000, 9, 9, 9);
    STATE = ST_IN; QUESTION = 24'h168000; DEC = 1'b1;
    tick;
    DEC = 1'b0; COUNT1_OUT = 4'd2; COUNT2_OUT = 4'd2; COUNT3_OUT = 4'd2;
    tick;
    chk("abort_busy_mul1", 32'(BUSY), 1);
    STATE = ST_OTHER;
    tick;
    chk("abort_idle", 32'(BUSY), 0);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      tick;
      if (RES_VALID !== 1'b0) pulses++;
    end
    chk("abort_no_valid", 32'(pulses), 0);
    chk("abort_result", 32'(RESULT), 32'(exp_result));

    // DEC held high: judgments restart every 5 edges
    STATE = ST_IN; QUESTION = 24'h729000;
    COUNT1_OUT = 4'd9; COUNT2_OUT = 4'd9; COUNT3_OUT = 4'd9; DEC = 1'b1;
    pulses = 0; p0 = -1; p1 = -1;
    for (int k = 0; k < 12; k++) begin
      tick;
      if (RES_VALID === 1'b1) begin
        pulses++;
        if (p0 < 0) p0 = k; else if (p1 < 0) p1 = k;
        chk("held_result", 32'(RESULT), 1);
      end
    end
    note_verdict(1); note_verdict(1);
    chk("held_pulses", 32'(pulses), 2);
    chk("held_first", 32'(p0), 4);
    chk("held_gap", 32'(p1 - p0), 5);
    chk("held_streak", 32'(STREAK), 32'(exp_streak()));
    DEC = 1'b0;
    tick;
    chk("mul2_busy", 32'(BUSY), 1);
    RST = 1'b1;
    tick;
    exp_result = 0; streak_ref = 0;
    chk("midrst_result", 32'(RESULT), 0);
    chk("midrst_valid", 32'(RES_VALID), 0);
    chk("midrst_busy", 32'(BUSY), 0);
    chk("midrst_streak", 32'(STREAK), 0);
    RST = 1'b0; STATE = ST_OTHER;
    tick;

    // Ten correct answers saturate the streak
    for (int i = 0; i < 10; i++) begin
      a = int'($urandom_range(9, 1)); b = int'($urandom_range(9, 1)); c = int'($urandom_range(9, 1));
      do_judge(bcd_question(a * b * c), a, b, c);
    end

    // Random mix of right, wrong and malformed questions
    for (int i = 0; i < 25; i++) begin
      a = int'($urandom_range(9, 0)); b = int'($urandom_range(9, 0)); c = int'($urandom_range(9, 0));
      case ($urandom_range(2, 0))
        0:       q = bcd_question(a * b * c);
        1:       q = bcd_question(int'($urandom_range(999, 0)));
        default: q = 24'($urandom);
      endcase
      do_judge(q, a, b, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
